// File: rtl/frogger_pkg.sv
// rtl/frogger_pkg.sv - shared types and defaults for the frogger move-input block
//
// Purpose : direction encoding, input FSM state encoding, default timing
//           constants and the key priority helper.
// Ports   : none (package)
package frogger_pkg;

  typedef enum logic [1:0] {
    DIR_R = 2'd0,
    DIR_L = 2'd1,
    DIR_U = 2'd2,
    DIR_D = 2'd3
  } move_dir_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FIRE     = 2'd1,
    ST_WAIT_REL = 2'd2
  } input_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEFAULT_REPEAT_DELAY    = 25_000_000;
  localparam int DEFAULT_REPEAT_PERIOD   = 10_000_000;

  // held bit order is {d,u,l,r}; R wins over L over U over D
  function automatic move_dir_t pri_dir(input logic [3:0] held);
    if (held[0])      return DIR_R;
    else if (held[1]) return DIR_L;
    else if (held[2]) return DIR_U;
    else              return DIR_D;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two-flop synchroniser plus debouncer for one raw key
//
// Purpose : bring one asynchronous active-low key into the clock domain and
//           accept a new level only after it has been stable long enough.
// Ports   : clk       in  1  system clock
//           rst       in  1  asynchronous active-high reset
//           i_key_n   in  1  raw key, active-low, asynchronous
//           o_level   out 1  debounced level, active-high (1 = pressed)
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key_n,
  output logic o_level
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1_n;
  logic             r_sync2_n;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_synced;

  // Sync flops reset to 1 so a key held through reset looks released and
  // must be re-debounced afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1_n <= 1'b1;
      r_sync2_n <= 1'b1;
    end else begin
      r_sync1_n <= i_key_n;
      r_sync2_n <= r_sync1_n;
    end
  end

  assign w_synced = ~r_sync2_n;

  // Counter only runs while synced and stable disagree, so it saturates at
  // CNT_LAST by accepting the new level rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (w_synced == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt    <= '0;
      r_stable <= w_synced;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_level = r_stable;

endmodule

// File: rtl/frogger_move_input.sv
// rtl/frogger_move_input.sv - key conditioning into single-cycle move commands
//
// Purpose : four debounced keys feed a priority/lockout FSM that emits one
//           move_valid pulse per press with a 2-bit direction code.
// Ports   : CLOCK_50    in  1  system clock, 50 MHz
//           reset       in  1  asynchronous active-high reset
//           move_r/l/u/d in 1  raw keys, active-low, asynchronous
//           move_valid  out 1  one-cycle pulse: a move is commanded
//           move_dir    out 2  0=R 1=L 2=U 3=D, held between pulses
//           keys_held   out 4  debounced levels, active-high, {d,u,l,r}
// Config  : define AUTO_REPEAT_EN to add auto-repeat while the latched key
//           stays held (adds REPEAT_DELAY / REPEAT_PERIOD parameters).
module frogger_move_input
  import frogger_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
`endif
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       move_r,
  input  logic       move_l,
  input  logic       move_u,
  input  logic       move_d,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic [3:0] keys_held
);

  logic [3:0]   w_raw_n;
  logic [3:0]   w_held;
  input_state_t r_state;
  input_state_t w_next;
  move_dir_t    r_lat_dir;
  move_dir_t    r_move_dir;
  logic         r_move_valid;
  logic         w_fire;
  logic         w_any_held;

  assign w_raw_n    = {move_d, move_u, move_l, move_r};
  assign w_any_held = |w_held;

  for (genvar g = 0; g < 4; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk     (CLOCK_50),
      .rst     (reset),
      .i_key_n (w_raw_n[g]),
      .o_level (w_held[g])
    );
  end

  // State register; the direction is latched on the IDLE->FIRE transition so
  // later key changes cannot alter the commanded move.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_lat_dir <= DIR_R;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_any_held) begin
        r_lat_dir <= pri_dir(w_held);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_any_held) w_next = ST_FIRE;
      ST_FIRE:     w_next = ST_WAIT_REL;
      ST_WAIT_REL: if (!w_any_held) w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

`ifdef AUTO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = (REP_MAX > 2) ? $clog2(REP_MAX) : 1;

  logic [REP_W-1:0] r_rep_cnt;
  logic             r_rep_live;
  logic             w_lat_held;
  logic             w_rep_fire;

  assign w_lat_held = w_held[r_lat_dir];

  // Countdown reaches zero on the cycle before each repeat pulse is
  // registered; once the latched key drops, repeats stay off until IDLE.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_rep_cnt  <= '0;
      r_rep_live <= 1'b0;
    end else if (r_state == ST_FIRE) begin
      r_rep_cnt  <= REP_W'(REPEAT_DELAY - 1);
      r_rep_live <= 1'b1;
    end else if (r_state == ST_WAIT_REL) begin
      if (!w_lat_held) begin
        r_rep_live <= 1'b0;
      end else if (r_rep_cnt == '0) begin
        r_rep_cnt <= REP_W'(REPEAT_PERIOD - 1);
      end else begin
        r_rep_cnt <= r_rep_cnt - 1'b1;
      end
    end else begin
      r_rep_live <= 1'b0;
    end
  end

  assign w_rep_fire = (r_state == ST_WAIT_REL) && r_rep_live && w_lat_held &&
                      (r_rep_cnt == '0);
`endif

  always_comb begin
    w_fire = (r_state == ST_FIRE);
`ifdef AUTO_REPEAT_EN
    if (w_rep_fire) w_fire = 1'b1;
`endif
  end

  // Registered outputs: the pulse appears one edge after the FIRE state.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_move_valid <= 1'b0;
      r_move_dir   <= DIR_R;
    end else begin
      r_move_valid <= w_fire;
      if (w_fire) r_move_dir <= r_lat_dir;
    end
  end

  assign move_valid = r_move_valid;
  assign move_dir   = r_move_dir;
  assign keys_held  = w_held;

endmodule
